pwm_capture: RTL and testbench

Measures an incoming PWM waveform and reports its period and high time in clock cycles. It is the receive-side counterpart of the `pwm` generator: it can be looped back from the PMOD output to check `pwm`/sequencer settings in hardware, or used to decode an external PWM control input. It sits on the same single clock as the PWM path and emits one registered measurement per completed PWM cycle.

---
 rtl/pwm_pkg.sv | 22 ++
 rtl/sync_edge_detect.sv | 43 ++++
 rtl/pwm_capture.sv | 146 ++++++++++++++
 tb/tb_pwm_capture.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// pwm_pkg: shared definitions for the PWM generator and the PWM capture path.
//   PWM_WIDTH    - default counter/result width for both directions
//   cap_state_t  - capture FSM state encoding (IDLE, ARMED, HIGH, LOW)
//   sync_depth() - synchronizer depth with the two-flop floor applied
package pwm_pkg;

  localparam int PWM_WIDTH       = 16;
  localparam int MIN_SYNC_STAGES = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,  // waiting for a low level before arming
    ST_ARMED = 2'd1,  // waiting for the first rise of a measured cycle
    ST_HIGH  = 2'd2,  // counting high time
    ST_LOW   = 2'd3   // counting low time until the closing rise
  } cap_state_t;

  // A single flop is not a synchronizer; anything shallower is promoted to two.
  function automatic int sync_depth(input int stages);
    return (stages < MIN_SYNC_STAGES) ? MIN_SYNC_STAGES : stages;
  endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// sync_edge_detect: brings an asynchronous level into the i_clk domain and
// flags its edges.
//   i_clk     - system clock
//   i_reset   - synchronous, active-high reset; clears every flop to 0
//   i_async   - asynchronous input level
//   o_level   - synchronized level (s), SYNC_STAGES-1 cycles after first sample
//   o_rise    - s & ~s_prev, one cycle per rising edge of s
//   o_fall    - ~s & s_prev, one cycle per falling edge of s
module sync_edge_detect
  import pwm_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_async,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  localparam int STAGES = sync_depth(SYNC_STAGES);

  logic [STAGES-1:0] sync_q;
  logic              level_prev;

  // NOTE: every register here is updated with <= so all flops sample the
  // pre-edge values; a blocking chain would collapse the synchronizer.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      sync_q     <= '0;
      level_prev <= 1'b0;
    end else begin
      sync_q     <= {sync_q[STAGES-2:0], i_async};
      level_prev <= sync_q[STAGES-1];
    end
  end

  assign o_level = sync_q[STAGES-1];
  assign o_rise  = o_level & ~level_prev;
  assign o_fall  = ~o_level & level_prev;

endmodule

// File: rtl/pwm_capture.sv
// pwm_capture: measures period and high time of an incoming PWM waveform in
// i_clk cycles and publishes one registered result per completed cycle.
//   WIDTH         - counter/result width; longest measurable period 2^WIDTH-1
//   SYNC_STAGES   - synchronizer depth on i_pwm (two or more)
//   i_clk         - system clock
//   i_reset       - synchronous, active-high reset; discards any partial cycle
//   i_pwm         - PWM input, asynchronous to i_clk
//   o_period      - cycles from one accepted rise to the next
//   o_high        - cycles from a rise to the following fall
//   o_valid       - one-cycle pulse, o_period/o_high updated in the same cycle
//   o_timeout     - one-cycle pulse when no cycle completes within 2^WIDTH-1
//   o_stuck_level - level seen at the last timeout, held until the next one
module pwm_capture
  import pwm_pkg::*;
#(
  parameter int WIDTH       = PWM_WIDTH,
  parameter int SYNC_STAGES = 2
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_pwm,
  output logic [WIDTH-1:0] o_period,
  output logic [WIDTH-1:0] o_high,
  output logic             o_valid,
  output logic             o_timeout,
  output logic             o_stuck_level
);

  localparam int             STAGES = sync_depth(SYNC_STAGES);
  localparam logic [WIDTH-1:0] E_MAX  = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] E_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

  logic level;
  logic rise;
  logic fall;

  sync_edge_detect #(
    .SYNC_STAGES(STAGES)
  ) u_sync (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_async (i_pwm),
    .o_level (level),
    .o_rise  (rise),
    .o_fall  (fall)
  );

  // The synchronizer comes out of reset holding 0 regardless of the pin, so
  // its level is not trustworthy until a real sample has propagated through.
  // Without this, an input already high at reset release would look like
  // low -> rise and open a bogus measurement.
  logic [STAGES-1:0] prime_q;
  logic              primed;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      prime_q <= '0;
    end else begin
      prime_q <= {prime_q[STAGES-2:0], 1'b1};
    end
  end

  assign primed = prime_q[STAGES-1];

  // e_q counts cycles since the accepted rise: the rise cycle itself is
  // count 0, so the register is loaded with 1 on the rise and reads k in the
  // k-th cycle after it. It saturates so that a fall landing exactly on
  // E_MAX still leads to a timeout in LOW instead of wrapping.
  cap_state_t        state;
  logic [WIDTH-1:0]  e_q;
  logic [WIDTH-1:0]  e_inc;
  logic [WIDTH-1:0]  high_q;
  logic              e_at_max;

  assign e_at_max = (e_q == E_MAX);
  assign e_inc    = e_at_max ? e_q : (e_q + E_ONE);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state         <= ST_IDLE;
      e_q           <= '0;
      high_q        <= '0;
      o_period      <= '0;
      o_high        <= '0;
      o_valid       <= 1'b0;
      o_timeout     <= 1'b0;
      o_stuck_level <= 1'b0;
    end else begin
      // NOTE: pulse outputs default low at the top of the clocked block so
      // every path through the case below leaves them defined for one cycle.
      o_valid   <= 1'b0;
      o_timeout <= 1'b0;

      case (state)
        ST_IDLE: begin
          // Only a genuine low level re-arms; a pulse already in progress
          // would otherwise be measured short.
          if (primed && !level) begin
            state <= ST_ARMED;
          end
        end

        ST_ARMED: begin
          if (rise) begin
            e_q   <= E_ONE;
            state <= ST_HIGH;
          end
        end

        ST_HIGH: begin
          e_q <= e_inc;
          if (fall) begin
            high_q <= e_q;
            state  <= ST_LOW;
          end else if (e_at_max) begin
            o_timeout     <= 1'b1;
            o_stuck_level <= level;
            state         <= ST_IDLE;
          end
        end

        ST_LOW: begin
          // The closing rise is checked before the timeout so a rise landing
          // exactly on E_MAX is still reported as a full cycle.
          if (rise) begin
            o_period <= e_q;
            o_high   <= high_q;
            o_valid  <= 1'b1;
            e_q      <= E_ONE;
            state    <= ST_HIGH;
          end else begin
            e_q <= e_inc;
            if (e_at_max) begin
              o_timeout     <= 1'b1;
              o_stuck_level <= level;
              state         <= ST_IDLE;
            end
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pwm_capture.sv
// tb_pwm_capture: directed stimulus on two capture instances (WIDTH 16 and 8)
// with a scoreboard of expected results and a separate monitor that pops
// and compares whenever a DUT pulses o_valid or o_timeout.
module tb_pwm_capture;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        rst0, rst1, pwm0, pwm1;
  logic [15:0] per0, hi0;
  logic [7:0]  per1, hi1;
  logic        v0, t0, s0, v1, t1, s1;

  pwm_capture #(.WIDTH(16), .SYNC_STAGES(2)) dut16 (
    .i_clk(clk), .i_reset(rst0), .i_pwm(pwm0),
    .o_period(per0), .o_high(hi0), .o_valid(v0),
    .o_timeout(t0), .o_stuck_level(s0)
  );

  pwm_capture #(.WIDTH(8), .SYNC_STAGES(2)) dut8 (
    .i_clk(clk), .i_reset(rst1), .i_pwm(pwm1),
    .o_period(per1), .o_high(hi1), .o_valid(v1),
    .o_timeout(t1), .o_stuck_level(s1)
  );

  typedef struct {
    int period;
    int high;
    bit stuck;
    int at;      // cycle count at which the monitor should see the pulse
  } exp_t;

  exp_t vq[2][$];
  exp_t tq[2][$];

  int n_checks = 0;
  int n_pass   = 0;

  bit pend[2];
  int pend_h[2];
  int pend_p[2];
  int tmax[2] = '{65535, 255};

  // An input change driven at a negedge with cycle count n shows up on a
  // registered output at the negedge where the count reads n+3 (two
  // synchronizer flops plus the output register).
  localparam int LAT = 3;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic drive(input int d, input bit lvl);
    if (d == 0) pwm0 = lvl;
    else        pwm1 = lvl;
  endtask

  task automatic hold(input int d, input bit lvl, input int n);
    drive(d, lvl);
    repeat (n) @(negedge clk);
  endtask

  // Emits one PWM cycle. Its rise closes the previous cycle, whose result
  // is queued here with the cycle at which it must appear.
  task automatic pulse(input int d, input int h, input int p);
    exp_t e;
    if (pend[d]) begin
      e.period = pend_p[d];
      e.high   = pend_h[d];
      e.stuck  = 1'b0;
      e.at     = cyc + LAT;
      vq[d].push_back(e);
    end
    pend[d]   = 1'b1;
    pend_h[d] = h;
    pend_p[d] = p;
    hold(d, 1'b1, h);
    hold(d, 1'b0, p - h);
  endtask

  // A rise followed by h high cycles and len-h low cycles, long enough that
  // no further edge arrives before the count saturates.
  task automatic stuck_pulse(input int d, input int h, input int len, input bit lvl);
    exp_t e;
    if (pend[d]) begin
      e.period = pend_p[d];
      e.high   = pend_h[d];
      e.stuck  = 1'b0;
      e.at     = cyc + LAT;
      vq[d].push_back(e);
    end
    e.period = 0;
    e.high   = 0;
    e.stuck  = lvl;
    e.at     = cyc + tmax[d] + LAT;
    tq[d].push_back(e);
    pend[d] = 1'b0;
    hold(d, 1'b1, h);
    hold(d, 1'b0, len - h);
  endtask

  task automatic check_zero(input int d);
    if (d == 0) begin
      check("dut16 reset o_period", int'(per0), 0);
      check("dut16 reset o_high", int'(hi0), 0);
      check("dut16 reset o_valid", int'(v0), 0);
      check("dut16 reset o_timeout", int'(t0), 0);
      check("dut16 reset o_stuck_level", int'(s0), 0);
    end else begin
      check("dut8 reset o_period", int'(per1), 0);
      check("dut8 reset o_high", int'(hi1), 0);
      check("dut8 reset o_valid", int'(v1), 0);
      check("dut8 reset o_timeout", int'(t1), 0);
      check("dut8 reset o_stuck_level", int'(s1), 0);
    end
  endtask

  task automatic mon(input int d, input bit v, input bit t,
                     input int per, input int hi, input bit st);
    exp_t e;
    string tag;
    tag = (d == 0) ? "dut16" : "dut8";
    if (v || t) check({tag, " valid_and_timeout_together"}, int'(v && t), 0);
    if (v) begin
      if (vq[d].size() == 0) begin
        check({tag, " unexpected o_valid"}, int'(v), 0);
      end else begin
        e = vq[d].pop_front();
        check({tag, " o_period"}, per, e.period);
        check({tag, " o_high"}, hi, e.high);
        check({tag, " o_valid cycle"}, cyc, e.at);
      end
    end
    if (t) begin
      if (tq[d].size() == 0) begin
        check({tag, " unexpected o_timeout"}, int'(t), 0);
      end else begin
        e = tq[d].pop_front();
        check({tag, " o_stuck_level"}, int'(st), int'(e.stuck));
        check({tag, " o_timeout cycle"}, cyc, e.at);
      end
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      mon(0, v0, t0, int'(per0), int'(hi0), s0);
      mon(1, v1, t1, int'(per1), int'(hi1), s1);
    end
  end

  initial begin
    rst0 = 1'b1; rst1 = 1'b1; pwm0 = 1'b0; pwm1 = 1'b0;
    pend = '{1'b0, 1'b0};
    repeat (3) @(negedge clk);
    check_zero(0);
    check_zero(1);
    rst0 = 1'b0;
    rst1 = 1'b0;
    hold(0, 1'b0, 5);

    // Steady 10/3 wave, then minimum pulse, then 7/8 duty, then a 64/16 wave
    // as the pwm generator produces it with top=63, compare=16.
    repeat (5) pulse(0, 3, 10);
    repeat (4) pulse(0, 1, 2);
    repeat (4) pulse(0, 7, 8);
    repeat (4) pulse(0, 16, 64);

    // Reset while in LOW: the partial cycle must never be reported.
    pulse(0, 16, 36);
    pend[0] = 1'b0;
    rst0 = 1'b1;
    @(negedge clk);
    check_zero(0);

    // Release reset with the input already high.
    drive(0, 1'b1);
    @(negedge clk);
    rst0 = 1'b0;
    hold(0, 1'b1, 10);
    hold(0, 1'b0, 5);
    pulse(0, 4, 10);
    pulse(0, 4, 10);
    pend[0] = 1'b0;
    hold(0, 1'b0, 10);

    // WIDTH=8: stuck low, stuck high, re-arm, edge versus timeout.
    repeat (2) pulse(1, 3, 10);
    stuck_pulse(1, 3, 300, 1'b0);
    stuck_pulse(1, 300, 305, 1'b1);
    repeat (3) pulse(1, 3, 10);
    repeat (2) pulse(1, 3, 255);
    pulse(1, 3, 10);
    stuck_pulse(1, 3, 256, 1'b0);
    pulse(1, 3, 10);
    pend[1] = 1'b0;
    hold(1, 1'b0, 20);

    repeat (10) @(negedge clk);
    check("dut16 missing o_valid", vq[0].size(), 0);
    check("dut8 missing o_valid", vq[1].size(), 0);
    check("dut16 missing o_timeout", tq[0].size(), 0);
    check("dut8 missing o_timeout", tq[1].size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
